// File: rtl/reg_check_monitor.sv
// reg_check_monitor: runs for a bounded number of cycles (or until halted),
// snapshots a bank of live registers and their expected values, then walks
// the bank one register per cycle, counting enabled mismatches and recording
// the lowest mismatching index. Results hold in DONE until start or reset.
//
// Handshake: start is a level sampled on the rising edge and is only acted on
// in IDLE or DONE; halt is only acted on in RUN. There is no back-pressure:
// busy is high for the whole RUN+CHECK window and done/pass/fail_count/
// fail_idx/cycle_count are valid while done is high.
module reg_check_monitor #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4,
  parameter int CW    = 16,
  localparam int FCW  = $clog2(NREGS + 1),
  localparam int IW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic [CW-1:0]          run_cycles,
  input  logic [NREGS*WIDTH-1:0] reg_actual,
  input  logic [NREGS*WIDTH-1:0] reg_expected,
  input  logic [NREGS-1:0]       check_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [FCW-1:0]         fail_count,
  output logic [IW-1:0]          fail_idx,
  output logic [CW-1:0]          cycle_count,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  state_t               state;
  logic [IW-1:0]        chk_idx;
  logic [WIDTH-1:0]     snap_act [NREGS];
  logic [WIDTH-1:0]     snap_exp [NREGS];
  logic [NREGS-1:0]     snap_mask;

  logic [CW:0]          cc_plus;
  logic                 limit_hit;
  logic                 mism;
  logic [FCW-1:0]       fc_next;

  // The FSM state is visible for debug and checker binding.
  assign state_dbg = state;

  // One extra bit so cycle_count+1 never wraps in the limit comparison.
  assign cc_plus   = {1'b0, cycle_count} + (CW+1)'(1);
  assign limit_hit = (cc_plus >= {1'b0, run_cycles});

  // Mismatch of the register currently examined, using snapshot data only.
  assign mism    = snap_mask[chk_idx] & (snap_act[chk_idx] != snap_exp[chk_idx]);
  assign fc_next = fail_count + FCW'(mism);

  // Main control FSM with registered outputs and snapshot storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      fail_idx    <= '0;
      cycle_count <= '0;
      chk_idx     <= '0;
      snap_mask   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        snap_act[i] <= '0;
        snap_exp[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A new run clears the previous results before counting starts.
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_count  <= '0;
            fail_idx    <= '0;
            cycle_count <= '0;
          end
        end

        S_RUN: begin
          cycle_count <= cycle_count + CW'(1);
          // Limit and halt together still give a single move to CHECK.
          if (limit_hit || halt) begin
            state     <= S_CHECK;
            chk_idx   <= '0;
            snap_mask <= check_mask;
            for (int i = 0; i < NREGS; i++) begin
              snap_act[i] <= reg_actual[i*WIDTH +: WIDTH];
              snap_exp[i] <= reg_expected[i*WIDTH +: WIDTH];
            end
          end
        end

        S_CHECK: begin
          if (mism) begin
            fail_count <= fc_next;
            // Only the first (lowest) mismatching index is recorded.
            if (fail_count == '0) begin
              fail_idx <= chk_idx;
            end
          end
          if (chk_idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fc_next == '0);
          end else begin
            chk_idx <= chk_idx + IW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_check_monitor.sv
// Testbench for reg_check_monitor (WIDTH=32, NREGS=4, CW=16): directed cases
// followed by randomized runs, all compared against a behavioural model.
module tb_reg_check_monitor;

  localparam int WIDTH = 32;
  localparam int NREGS = 4;
  localparam int CW    = 16;
  localparam int BUDGET = 400;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   start;
  logic                   halt;
  logic [CW-1:0]          run_cycles;
  logic [NREGS*WIDTH-1:0] reg_actual;
  logic [NREGS*WIDTH-1:0] reg_expected;
  logic [NREGS-1:0]       check_mask;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [2:0]             fail_count;
  logic [1:0]             fail_idx;
  logic [CW-1:0]          cycle_count;
  logic [1:0]             state_dbg;

  reg_check_monitor #(.WIDTH(WIDTH), .NREGS(NREGS), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .run_cycles   (run_cycles),
    .reg_actual   (reg_actual),
    .reg_expected (reg_expected),
    .check_mask   (check_mask),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_count   (fail_count),
    .fail_idx     (fail_idx),
    .cycle_count  (cycle_count),
    .state_dbg    (state_dbg)
  );

  // Scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus values for the current case
  logic [WIDTH-1:0] act_v [NREGS];
  logic [WIDTH-1:0] exp_v [NREGS];
  logic [NREGS-1:0] mask_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: count and first index of enabled mismatches
  function automatic int model_fail_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++)
      if (mask_v[i] && act_v[i] != exp_v[i]) n++;
    return n;
  endfunction

  function automatic int model_fail_idx();
    for (int i = 0; i < NREGS; i++)
      if (mask_v[i] && act_v[i] != exp_v[i]) return i;
    return 0;
  endfunction

  // Expected number of RUN cycles given the limit and the halt cycle
  function automatic int model_run_len(input int rc, input int halt_at);
    int len;
    len = (rc < 1) ? 1 : rc;
    if (halt_at > 0 && halt_at < len) len = halt_at;
    return len;
  endfunction

  task automatic drive_regs();
    for (int i = 0; i < NREGS; i++) begin
      reg_actual[i*WIDTH +: WIDTH]   = act_v[i];
      reg_expected[i*WIDTH +: WIDTH] = exp_v[i];
    end
    check_mask = mask_v;
  endtask

  task automatic set_base_case();
    exp_v[0] = 32'd9; exp_v[1] = 32'd15; exp_v[2] = 32'd2; exp_v[3] = 32'd30;
    for (int i = 0; i < NREGS; i++) act_v[i] = exp_v[i];
    mask_v = 4'b1111;
  endtask

  // Driver: one complete run. halt_at = RUN cycle number (1-based) in which
  // halt is high, 0 for none; reset_at_idx >= 0 pulls reset during CHECK.
  task automatic run_case(input string name, input int rc, input int halt_at,
                          input bit start_in_run, input bit zero_in_check,
                          input int reset_at_idx);
    int eff, busy_n, cyc, exp_fc, exp_fi;
    bit aborted;
    eff    = model_run_len(rc, halt_at);
    exp_fc = model_fail_count();
    exp_fi = model_fail_idx();
    drive_regs();
    run_cycles = CW'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; cyc = 0; aborted = 0;
    while (!done && cyc < BUDGET) begin
      halt = 1'b0;
      start = 1'b0;
      if (busy) busy_n++;
      cyc++;
      if (halt_at > 0 && busy_n == halt_at) halt = 1'b1;
      if (start_in_run && busy_n == 2) start = 1'b1;
      if (zero_in_check && busy_n == eff + 1) reg_actual = '0;
      if (reset_at_idx >= 0 && busy_n == eff + 1 + reset_at_idx) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        aborted = 1;
        break;
      end
      @(negedge clk);
    end
    halt = 1'b0;
    start = 1'b0;

    if (aborted) begin
      check({name, " rst busy"}, busy, 0);
      check({name, " rst done"}, done, 0);
      check({name, " rst pass"}, pass, 0);
      check({name, " rst fail_count"}, fail_count, 0);
      check({name, " rst fail_idx"}, fail_idx, 0);
      check({name, " rst cycle_count"}, cycle_count, 0);
      return;
    end

    check({name, " finished in budget"}, (cyc < BUDGET), 1);
    check({name, " busy cycles"}, busy_n, eff + NREGS);
    check({name, " done"}, done, 1);
    check({name, " busy after"}, busy, 0);
    check({name, " pass"}, pass, (exp_fc == 0));
    check({name, " fail_count"}, fail_count, exp_fc);
    if (exp_fc != 0) check({name, " fail_idx"}, fail_idx, exp_fi);
    check({name, " cycle_count"}, cycle_count, eff);
    // Results must hold while start stays low
    repeat (3) @(negedge clk);
    check({name, " hold done"}, done, 1);
    check({name, " hold fail_count"}, fail_count, exp_fc);
    check({name, " hold cycle_count"}, cycle_count, eff);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    halt  = 1'b1;
    run_cycles = 16'd5;
    set_base_case();
    drive_regs();
    // start and halt held high during reset must have no effect
    repeat (4) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset fail_count", fail_count, 0);
    check("reset fail_idx", fail_idx, 0);
    check("reset cycle_count", cycle_count, 0);
    start = 1'b0;
    halt  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle stays idle", busy, 0);

    // All registers match
    set_base_case();
    run_case("pass", 10, 0, 0, 0, -1);

    // Two mismatches
    act_v[1] = 32'd14; act_v[3] = 32'd31;
    run_case("two_mism", 10, 0, 0, 0, -1);

    // Lower mismatch masked off
    mask_v = 4'b1101;
    run_case("masked", 10, 0, 0, 0, -1);

    // Early halt with an ignored start during RUN
    set_base_case();
    run_case("halt", 100, 3, 1, 0, -1);

    // Live registers zeroed during CHECK
    set_base_case();
    run_case("snapshot", 10, 0, 0, 1, -1);

    // Reset at CHECK index 2, then a clean rerun
    set_base_case();
    run_case("rst_check", 10, 0, 0, 0, 2);
    set_base_case();
    run_case("after_rst", 10, 0, 0, 0, -1);

    // run_cycles boundaries: 0 and 1 both give one RUN cycle
    run_case("rc0", 0, 0, 0, 0, -1);
    run_case("rc1", 1, 0, 0, 0, -1);
    // halt coinciding with the limit
    run_case("halt_eq_limit", 4, 4, 0, 0, -1);

    // Randomized runs
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREGS; i++) begin
        exp_v[i] = $urandom;
        act_v[i] = ($urandom_range(0, 1) == 1) ? (exp_v[i] ^ (32'h1 << $urandom_range(0, 31)))
                                                : exp_v[i];
      end
      mask_v = 4'($urandom_range(0, 15));
      run_case($sformatf("rand%0d", t), $urandom_range(0, 20),
               ($urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_check_monitor.md
REG_CHECK_MONITOR -- requirements
Module: reg_check_monitor

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: bit width of each checked register.
REQ-002 SHALL provide parameter NREGS, default 4: number of registers checked (minimum 1).
REQ-003 SHALL provide parameter CW, default 16: width of the run-cycle limit and the cycle counter.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begins a run; honoured in IDLE and DONE only.
REQ-007 SHALL have port halt  input  1  ends RUN early when sampled high.
REQ-008 SHALL have port run_cycles  input  CW  number of RUN cycles before checking.
REQ-009 SHALL have port reg_actual  input  NREGS*WIDTH  live register values, register i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port reg_expected  input  NREGS*WIDTH  expected values, same packing.
REQ-011 SHALL have port check_mask  input  NREGS  bit i=1 enables the check of register i.
REQ-012 SHALL have port busy  output  1  high in RUN and CHECK.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port pass  output  1  high in DONE when fail_count==0.
REQ-015 SHALL have port fail_count  output  clog2(NREGS+1)  number of enabled mismatches.
REQ-016 SHALL have port fail_idx  output  max(1,clog2(NREGS))  index of the lowest mismatching register.
REQ-017 SHALL have port cycle_count  output  CW  number of RUN cycles executed.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, CHECK and DONE.
REQ-019 IDLE: on start=1, SHALL clear cycle_count, fail_count and fail_idx, and enter RUN at the next edge.
REQ-020 RUN: cycle_count SHALL increment by 1 at every edge spent in RUN.
REQ-021 RUN: SHALL enter CHECK when cycle_count+1 >= run_cycles or halt=1; run_cycles 0 or 1 gives exactly one RUN cycle.
REQ-022 On the RUN->CHECK edge, SHALL snapshot reg_actual and reg_expected into internal registers and set the check index to 0; later input changes SHALL NOT affect the result.
REQ-023 CHECK: SHALL examine one register per cycle, index 0 to NREGS-1, so CHECK lasts exactly NREGS cycles.
REQ-024 CHECK: an enabled index with snapshot actual != expected SHALL increment fail_count; fail_idx SHALL be loaded only on the first mismatch.
REQ-025 Masked indices SHALL never count as mismatches.
REQ-026 After index NREGS-1, SHALL enter DONE.
REQ-027 DONE: done=1 and pass=(fail_count==0); results SHALL hold until start or reset.
REQ-028 DONE: start=1 SHALL behave as in IDLE (clear results, enter RUN).
REQ-029 start SHALL be ignored in RUN and CHECK.
REQ-030 halt SHALL be ignored outside RUN.
REQ-031 If halt and the count limit coincide, SHALL perform a single transition to CHECK.
REQ-032 cycle_count SHALL NOT wrap, since run_cycles bounds it to at most 2^CW-1.
REQ-033 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-034 reset=0 at a rising edge SHALL force IDLE from any state, including mid-RUN and mid-CHECK.
REQ-035 Reset SHALL clear busy, done, pass, fail_count, fail_idx, cycle_count, the snapshot registers and the check index to 0.
REQ-036 While reset=0, start and halt SHALL be ignored.

Verification (WIDTH=32, NREGS=4, CW=16)
REQ-037 Pass case: expected R0..R3 = 9,15,2,30, actual equal, mask=4'b1111, run_cycles=10, start pulse -> busy for 14 cycles, then done=1, pass=1, fail_count=0, cycle_count=10.
REQ-038 Two mismatches: actual R1=14, R3=31, otherwise as REQ-037 -> pass=0, fail_count=2, fail_idx=1.
REQ-039 Masked mismatch: as REQ-038 with mask=4'b1101 -> fail_count=1, fail_idx=3.
REQ-040 Early halt: run_cycles=100, halt high in the 3rd RUN cycle -> cycle_count=3, CHECK begins on the next cycle, done 4 cycles later; start pulsed during RUN has no effect.
REQ-041 Snapshot isolation: reg_actual changed to all zeros during CHECK -> result identical to REQ-037.
REQ-042 Reset mid-CHECK: reset=0 for one edge during CHECK index 2 -> IDLE with all outputs 0; a new start then reproduces REQ-037.
